// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encoding, default width and counter sizing for serial_subtractor8.
package serial_sub_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;
   localparam int SUB_WIDTH = 8;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit cell computing x - y - bin.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);
   assign diff = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor8.sv
// serial_subtractor8: bit-serial a - b - c, LSB first, one bit per clock with start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor8
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);
   localparam int CW = clog2(WIDTH);
   logic [1:0] state, state_n;
   logic [WIDTH-1:0] sa, sb, res;
   logic [CW-1:0] cnt;
   logic brw, diff, nbrw, last, load, shift, fin;
   full_subtractor u_fs (
      .x(sa[0]),
      .y(sb[0]),
      .bin(brw),
      .diff(diff),
      .bout(nbrw)
   );
   assign last = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state == ST_IDLE  ? (start ? ST_SHIFT : ST_IDLE) :
                state == ST_SHIFT ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
   end
   always_comb begin
      load  = state == ST_IDLE && start;
      shift = state == ST_SHIFT;
      fin   = state == ST_DONE;
   end
   // results are published on the edge leaving DONE, so d/bout never change mid-shift
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         d    <= '0;
         bout <= 1'b0;
         sa   <= '0;
         sb   <= '0;
         res  <= '0;
         brw  <= 1'b0;
         cnt  <= '0;
      end else begin
         busy <= state_n != ST_IDLE;
         done <= fin;
         if (load) begin
            sa  <= a;
            sb  <= b;
            brw <= c;
            cnt <= '0;
         end
         if (shift) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            brw <= nbrw;
            res <= {diff, res[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
         end
         if (fin) begin
            d    <= res;
            bout <= brw;
         end
      end
   end
`ifdef SERIAL_SUB_OVF_EN
   logic ovf_r;
   // borrow into the MSB xor borrow out of it, taken on the last shift
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (shift && last) ovf_r <= brw ^ nbrw;
         if (fin) ovf <= ovf_r;
      end
   end
`endif
endmodule

// File: tb/tb_serial_subtractor8.sv
// tb_serial_subtractor8: directed and random checks of serial_subtractor8 against an arithmetic model.
module tb_serial_subtractor8;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, c = 1'b0;
   logic [7:0] a = '0, b = '0;
   logic busy, done, bout;
   logic [7:0] d;
`ifdef SERIAL_SUB_OVF_EN
   logic ovf;
`endif
   int total = 0, bad = 0;
   serial_subtractor8 dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .a(a),
      .b(b),
      .c(c),
      .busy(busy),
      .done(done),
      .d(d),
`ifdef SERIAL_SUB_OVF_EN
      .ovf(ovf),
`endif
      .bout(bout)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask
   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (!done && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask
   task automatic check_result(input string tag, input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
      int r, s;
      logic [7:0] ed;
      r  = int'(ta) - int'(tb_) - int'(tc);
      ed = r[7:0];
      check({tag, "_d"}, 32'(d), 32'(ed));
      check({tag, "_bout"}, 32'(bout), 32'(r < 0));
`ifdef SERIAL_SUB_OVF_EN
      s = int'($signed(ta)) - int'($signed(tb_)) - int'(tc);
      check({tag, "_ovf"}, 32'(ovf), 32'(s < -128 || s > 127));
`else
      s = 0;
`endif
   endtask
   task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
      int n;
      @(negedge clk);
      a = ta; b = tb_; c = tc; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      check({tag, "_busy"}, 32'(busy), 1);
      wait_done(20, n);
      check({tag, "_lat"}, n, 9);
      check_result(tag, ta, tb_, tc);
   endtask
   initial begin
      int n, k, edges[$];
      logic [7:0] ra, rb;
      logic rc;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_d", 32'(d), 0);
      check("rst_bout", 32'(bout), 0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         n += int'(done);
      end
      check("idle_done", n, 0);
      op("basic", 8'h0C, 8'h0B, 1'b0);
      op("brw0", 8'h00, 8'h02, 1'b0);
      op("brw1", 8'h07, 8'h08, 1'b0);
      op("brw2", 8'hF2, 8'h0F, 1'b1);
      op("ovf0", 8'h80, 8'h01, 1'b0);
      op("ovf1", 8'h7F, 8'hFF, 1'b0);
      op("ovf2", 8'h05, 8'h03, 1'b0);
      op("zero", 8'h00, 8'h00, 1'b1);
      op("max", 8'hFF, 8'hFF, 1'b1);
      for (int i = 0; i < 30; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         op("rand", ra, rb, rc);
      end
      // second start three cycles into the operation must be ignored
      @(negedge clk);
      a = 8'h0C; b = 8'h0B; c = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 8'h09; b = 8'h07; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(20, n);
      check("ovl_seen", 32'(done), 1);
      check_result("ovl", 8'h0C, 8'h0B, 1'b0);
      @(posedge clk);
      #1;
      check("ovl_single", 32'(done), 0);
      @(negedge clk);
      a = 8'h09; b = 8'h07; c = 1'b0; start = 1'b1;
      k = 0;
      while (edges.size() < 3 && k < 60) begin
         @(posedge clk);
         #1;
         k++;
         if (done) begin
            edges.push_back(k);
            check("held_d", 32'(d), 32'h02);
         end
      end
      check("held_cnt", edges.size(), 3);
      if (edges.size() == 3) begin
         check("held_gap1", edges[1] - edges[0], 10);
         check("held_gap2", edges[2] - edges[1], 10);
      end
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (busy && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("held_idle", 32'(busy), 0);
      @(negedge clk);
      a = 8'h0C; b = 8'h0B; c = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_d", 32'(d), 0);
      check("abort_bout", 32'(bout), 0);
      check("abort_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         n += int'(done);
      end
      check("abort_nodone", n, 0);
      op("fresh", 8'h05, 8'h05, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
